// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main control unit.
// Optional bne support is compiled in with MC_BNE_EN.
package mc_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned FC_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_FAULT   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [FC_W-1:0] FC_NONE    = 2'b00;
    localparam logic [FC_W-1:0] FC_TIMEOUT = 2'b01;
    localparam logic [FC_W-1:0] FC_ILLEGAL = 2'b10;

    // States that hold a memory access open and are watched by the timer
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller-to-datapath bundle: opcode/ready in, selects and strobes out.
interface mc_main_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [OP_W-1:0]  Opcode;
    logic             MemReady;
    logic             MemReq;
    logic             MemtoReg;
    logic             RegDst;
    logic             IorD;
    logic             ALUSrcA;
    logic [SEL_W-1:0] PCSrc;
    logic [SEL_W-1:0] ALUSrcB;
    logic [SEL_W-1:0] ALUOp;
    logic             IRWrite;
    logic             PCWrite;
    logic             MemWrite;
    logic             RegWrite;
    logic             Branch;
    logic             BranchNe;
    logic             Fault;
    logic [FC_W-1:0]  FaultCause;

    modport master (
        input  Opcode, MemReady,
        output MemReq, MemtoReg, RegDst, IorD, ALUSrcA, PCSrc, ALUSrcB, ALUOp,
               IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNe,
               Fault, FaultCause
    );

    modport slave (
        output Opcode, MemReady,
        input  MemReq, MemtoReg, RegDst, IorD, ALUSrcA, PCSrc, ALUSrcB, ALUOp,
               IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNe,
               Fault, FaultCause
    );

endinterface

// File: rtl/mc_mem_timer.sv
// Memory-access watchdog: flags a stall that has lasted MEM_TIMEOUT cycles.
// MEM_TIMEOUT=0 removes the counter entirely.
module mc_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    if (MEM_TIMEOUT == 0) begin : g_off
        logic w_unused;
        assign w_unused = ^{clk, rst, busy, ready};
        assign expired  = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
        logic [CW-1:0] r_count;

        // Leaving a memory state clears the count, so every entry starts at zero
        always_ff @(posedge clk) begin
            if (rst || ready || !busy) begin
                r_count <= '0;
            end else if (r_count != CW'(MEM_TIMEOUT)) begin
                r_count <= r_count + CW'(1);
            end
        end

        assign expired = busy && !ready && (r_count == CW'(MEM_TIMEOUT));
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM with memory handshake, watchdog and sticky fault.
// Define MC_BNE_EN to decode bne into the branch state with BranchNe set.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mc_main_ctrl_if.master bus
);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_is_sw;
    logic            r_fault;
    logic [FC_W-1:0] r_fault_cause;
    logic [FC_W-1:0] w_next_cause;
    logic            w_busy;
    logic            w_expired;
`ifdef MC_BNE_EN
    logic            r_bne;
`endif

    assign w_busy = is_mem_state(r_state);

    mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .busy    (w_busy),
        .ready   (bus.MemReady),
        .expired (w_expired)
    );

    // State register plus the opcode class captured in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_is_sw       <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= FC_NONE;
`ifdef MC_BNE_EN
            r_bne         <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_is_sw <= (bus.Opcode == OP_SW);
`ifdef MC_BNE_EN
                r_bne   <= (bus.Opcode == OP_BNE);
`endif
            end
            if (w_next_cause != FC_NONE) begin
                r_fault       <= 1'b1;
                r_fault_cause <= w_next_cause;
            end
        end
    end

    // Next-state logic; a nonzero w_next_cause marks the transition into FAULT
    always_comb begin
        w_next_state = r_state;
        w_next_cause = FC_NONE;
        case (r_state)
            S_FETCH: begin
                if (bus.MemReady) begin
                    w_next_state = S_DECODE;
                end else if (w_expired) begin
                    w_next_state = S_FAULT;
                    w_next_cause = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next_state = S_BRANCH;
`endif
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        w_next_state = S_FAULT;
                        w_next_cause = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR:  w_next_state = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.MemReady) begin
                    w_next_state = S_MEMWB;
                end else if (w_expired) begin
                    w_next_state = S_FAULT;
                    w_next_cause = FC_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (bus.MemReady) begin
                    w_next_state = S_FETCH;
                end else if (w_expired) begin
                    w_next_state = S_FAULT;
                    w_next_cause = FC_TIMEOUT;
                end
            end
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
            S_FAULT:   w_next_state = S_FAULT;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Moore outputs; strobes tied to MemReady only inside the access states
    always_comb begin
        bus.MemReq   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegDst   = 1'b0;
        bus.IorD     = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.PCSrc    = PCSRC_ALU;
        bus.ALUSrcB  = SRCB_REG;
        bus.ALUOp    = ALUOP_ADD;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.Branch   = 1'b0;
        bus.BranchNe = 1'b0;
        if (rst) begin
            bus.ALUSrcB = SRCB_FOUR;
        end else begin
            case (r_state)
                S_FETCH: begin
                    bus.ALUSrcB = SRCB_FOUR;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                    bus.MemReq  = 1'b1;
                end
                S_DECODE: bus.ALUSrcB = SRCB_IMMSH;
                S_MEMADR, S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    bus.IorD   = 1'b1;
                    bus.MemReq = 1'b1;
                end
                S_MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemReq   = 1'b1;
                    bus.MemWrite = bus.MemReady;
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_EXECUTE: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_ADDIWB: bus.RegWrite = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = ALUOP_SUB;
                    bus.PCSrc   = PCSRC_ALUOUT;
                    bus.Branch  = 1'b1;
`ifdef MC_BNE_EN
                    bus.BranchNe = r_bne;
`endif
                end
                S_JUMP: begin
                    bus.PCSrc   = PCSRC_JUMP;
                    bus.PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Fault      = r_fault;
    assign bus.FaultCause = r_fault_cause;

endmodule
